// File: rtl/cycle_cooling_ctrl.sv
// Cycle-cooling fan controller: Moore FSM driving fan enable, a swept louvre angle and fan PWM.
// Latency: one clk from sampled inputs to registered outputs (outputs follow the new state).
// No flow control: inputs are sampled every cycle; optional PWM enabled by CYCLE_COOL_PWM_EN.
module cycle_cooling_ctrl #(
   parameter int unsigned DATA_W       = 3,
   parameter int unsigned CAL_THRESH   = 1,
   parameter int unsigned TEMP_THRESH  = 1,
   parameter int unsigned AIR_THRESH   = 0,
   parameter int unsigned ANGLE_MAX    = 5,
   parameter int unsigned SWEEP_DIV    = 4,
   parameter int unsigned COOLDOWN_CYC = 8,
   parameter int unsigned PWM_W        = 3
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [DATA_W-1:0]              calorie_i,
   input  logic [DATA_W-1:0]              temperature_i,
   input  logic                           pressure_i,
   input  logic [DATA_W-1:0]              air_pressure_i,
   output logic                           fan_o,
   output logic [$clog2(ANGLE_MAX+1)-1:0] fan_angle_o,
   output logic                           fan_pwm_o,
   output logic [1:0]                     state_o
);

   localparam int unsigned ANG_W  = $clog2(ANGLE_MAX + 1);
   localparam int unsigned DIV_W  = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
   localparam int unsigned COOL_W = $clog2(COOLDOWN_CYC + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] SWEEP  = 2'd2;
   localparam logic [1:0] HOLD   = 2'd3;

   // Thresholds and terminal values sized to the signals they are compared with.
   localparam logic [DATA_W-1:0] CAL_T     = DATA_W'(CAL_THRESH);
   localparam logic [DATA_W-1:0] TEMP_T    = DATA_W'(TEMP_THRESH);
   localparam logic [DATA_W-1:0] AIR_T     = DATA_W'(AIR_THRESH);
   localparam logic [ANG_W-1:0]  ANG_MAX   = ANG_W'(ANGLE_MAX);
   localparam logic [ANG_W-1:0]  ANG_ONE   = ANG_W'(1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SWEEP_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
   localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYC - 1);
   localparam logic [COOL_W-1:0] COOL_MAX  = COOL_W'(COOLDOWN_CYC);
   localparam logic [COOL_W-1:0] COOL_ONE  = COOL_W'(1);

   logic [1:0]        state_q, state_d;
   logic              fan_q, fan_d;
   logic [ANG_W-1:0]  angle_q, angle_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [COOL_W-1:0] cool_q, cool_d;
   logic              fan_pwm_q, fan_pwm_d;

   logic hot, start_ok, air_low, cool_done;

   assign hot      = temperature_i > TEMP_T;
   assign start_ok = (calorie_i > CAL_T) && hot;
   assign air_low  = air_pressure_i <= AIR_T;
   // The edge on which the cool streak would reach its target is itself the exit edge.
   assign cool_done = (state_q != IDLE) && !hot && (cool_q == COOL_LAST);

   // Next-state selection; cooldown exit outranks every other non-IDLE transition.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_ok) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (cool_done)        state_d = IDLE;
            else if (!pressure_i) state_d = SWEEP;
         end
         SWEEP: begin
            if (cool_done)    state_d = IDLE;
            else if (air_low) state_d = HOLD;
         end
         HOLD: begin
            if (cool_done)    state_d = IDLE;
            else if (air_low) state_d = ACTIVE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Consecutive-cool counter: runs only outside IDLE while temperature is at or below threshold.
   always_comb begin
      cool_d = '0;
      if ((state_q != IDLE) && !hot) begin
         cool_d = (cool_q == COOL_MAX) ? cool_q : cool_q + COOL_ONE;
      end
   end

   // Angle sweep: the divider restarts on SWEEP entry, the angle steps on each divider wrap.
   always_comb begin
      div_d   = '0;
      angle_d = '0;
      case (state_d)
         SWEEP: begin
            angle_d = angle_q;
            if (state_q == SWEEP) begin
               if (div_q == DIV_LAST) begin
                  angle_d = (angle_q == ANG_MAX) ? '0 : angle_q + ANG_ONE;
               end else begin
                  div_d = div_q + DIV_ONE;
               end
            end
         end
         HOLD:    angle_d = angle_q;
         default: angle_d = '0;
      endcase
   end

   assign fan_d = (state_d != IDLE);

`ifdef CYCLE_COOL_PWM_EN
   localparam logic [PWM_W-1:0] PWM_ONE = PWM_W'(1);

   logic [PWM_W-1:0] pwm_q, pwm_d, duty;

   // PWM period counter starts at zero when the fan turns on; duty tracks temperature directly.
   always_comb begin
      duty      = PWM_W'(temperature_i);
      pwm_d     = (fan_d && fan_q) ? pwm_q + PWM_ONE : '0;
      fan_pwm_d = fan_d && (pwm_d < duty);
   end

   // PWM counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) pwm_q <= '0;
      else       pwm_q <= pwm_d;
   end
`else
   assign fan_pwm_d = fan_d;
`endif

   // State and output registers; reset beats every other event.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         fan_q     <= 1'b0;
         angle_q   <= '0;
         div_q     <= '0;
         cool_q    <= '0;
         fan_pwm_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         fan_q     <= fan_d;
         angle_q   <= angle_d;
         div_q     <= div_d;
         cool_q    <= cool_d;
         fan_pwm_q <= fan_pwm_d;
      end
   end

   assign state_o     = state_q;
   assign fan_o       = fan_q;
   assign fan_angle_o = angle_q;
   assign fan_pwm_o   = fan_pwm_q;

endmodule
